// File: rtl/usb_in_arbiter_pkg.sv
// Shared types and helpers for the USB CDC IN-stream round-robin arbiter.
// Flattened per-source vectors are sliced through one common helper.
package usb_in_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int LEN_W_DEF = 24;
  localparam int MAX_SRC   = 8;
  localparam int SLICE_W   = 32;
  localparam int FLAT_W    = MAX_SRC * SLICE_W;

  typedef logic [2:0] src_idx_t;

  // Returns field idx (each w bits wide) of a flattened vector, zero-extended.
  // With w == SLICE_W the mask shift wraps to zero, so the mask becomes all ones.
  function automatic logic [SLICE_W-1:0] get_slice(input logic [FLAT_W-1:0] flat,
                                                   input src_idx_t         idx,
                                                   input int unsigned      w);
    logic [FLAT_W-1:0]  shifted;
    logic [SLICE_W-1:0] mask;
    shifted = flat >> (int'(idx) * w);
    mask    = (SLICE_W'(1) << w) - SLICE_W'(1);
    return shifted[SLICE_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester strictly after last_i,
// searched in circular order.
module rr_picker
  import usb_in_arbiter_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0] req_i,
  input  src_idx_t         last_i,
  output logic [N_SRC-1:0] grant_o,
  output src_idx_t         idx_o,
  output logic             any_o
);

  function automatic int next_idx(input src_idx_t last, input int k);
    return (int'(last) + k) % N_SRC;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path leaves one unassigned (no latch).
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!any_o && ((req_i & (N_SRC'(1) << next_idx(last_i, k))) != '0)) begin
        any_o   = 1'b1;
        grant_o = N_SRC'(1) << next_idx(last_i, k);
        idx_o   = src_idx_t'(next_idx(last_i, k));
      end
    end
  end

endmodule

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter sharing one usb_cdc IN byte stream between N_SRC sources;
// the stream stays locked to one source for a whole declared-length burst.
module usb_in_arbiter
  import usb_in_arbiter_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_SRC-1:0]       req_i,
  input  logic [N_SRC*LEN_W-1:0] len_i,
  input  logic [N_SRC*8-1:0]     data_i,
  input  logic [N_SRC-1:0]       valid_i,
  output logic [N_SRC-1:0]       ready_o,
  output logic [N_SRC-1:0]       grant_o,
  output logic [N_SRC-1:0]       done_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  output logic                   busy_o
);

  state_t           r_state, w_state_nxt;
  logic [N_SRC-1:0] r_grant, w_grant_nxt;
  logic [N_SRC-1:0] r_done, w_done_nxt;
  src_idx_t         r_gidx, w_gidx_nxt;
  src_idx_t         r_last, w_last_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;

  logic [N_SRC-1:0] w_pick_oh;
  src_idx_t         w_pick_idx;
  logic             w_any;
  logic [FLAT_W-1:0] w_data_flat, w_len_flat;
  logic [7:0]       w_data_sel;
  logic [LEN_W-1:0] w_len_pick;
  logic             w_valid_g, w_req_g, w_hs;

  rr_picker #(.N_SRC(N_SRC)) u_picker (
    .req_i  (req_i),
    .last_i (r_last),
    .grant_o(w_pick_oh),
    .idx_o  (w_pick_idx),
    .any_o  (w_any)
  );

  assign w_data_flat = FLAT_W'(data_i);
  assign w_len_flat  = FLAT_W'(len_i);
  assign w_data_sel  = 8'(get_slice(w_data_flat, r_gidx, 8));
  assign w_len_pick  = LEN_W'(get_slice(w_len_flat, w_pick_idx, LEN_W));

  // r_grant is all-zero outside XFER, so these masks also gate the IDLE case.
  assign w_valid_g = |(valid_i & r_grant);
  assign w_req_g   = |(req_i & r_grant);
  assign w_hs      = w_valid_g & in_ready_i;

  assign ready_o    = r_grant & {N_SRC{in_ready_i}};
  assign in_valid_o = w_valid_g;
  assign in_data_o  = (r_state == XFER) ? w_data_sel : 8'h00;
  assign grant_o    = r_grant;
  assign done_o     = r_done;
  assign busy_o     = (r_state == XFER);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = XFER;
          w_grant_nxt = w_pick_oh;
          w_gidx_nxt  = w_pick_idx;
          w_cnt_nxt   = w_len_pick;
        end
      end
      XFER: begin
        // A final handshake wins over a coincident request drop.
        if (w_hs) begin
          if (r_cnt == '0) begin
            w_done_nxt  = r_grant;
            w_grant_nxt = '0;
            w_last_nxt  = r_gidx;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end
        end else if (!w_req_g) begin
          w_grant_nxt = '0;
          w_last_nxt  = r_gidx;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_gidx  <= '0;
      r_last  <= src_idx_t'(N_SRC - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
